// File: rtl/pc_return_stack_pkg.sv
// rtl/pc_return_stack_pkg.sv - shared widths, reset PC and control-select encoding for fetch
package pc_return_stack_pkg;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    localparam logic [ADDR_W-1:0] RESET_PC  = 8'h00;
    localparam logic [ADDR_W-1:0] PC_STEP   = 8'h01;
    localparam logic [PTR_W-1:0]  PTR_ONE   = 3'd1;
    localparam logic [PTR_W:0]    CNT_ONE   = 4'd1;
    localparam logic [PTR_W:0]    CNT_FULL  = 4'd8;

    typedef enum logic [2:0] {
        SEL_SEQ      = 3'd0,
        SEL_REDIRECT = 3'd1,
        SEL_CALL     = 3'd2,
        SEL_RET      = 3'd3,
        SEL_ILLEGAL  = 3'd4
    } ctl_sel_e;

    // Only one-hot (or all-zero) control is legal; anything else is ILLEGAL.
    function automatic ctl_sel_e decode_sel(
        input logic redirect,
        input logic call,
        input logic ret
    );
        ctl_sel_e sel;
        case ({redirect, call, ret})
            3'b000:  sel = SEL_SEQ;
            3'b100:  sel = SEL_REDIRECT;
            3'b010:  sel = SEL_CALL;
            3'b001:  sel = SEL_RET;
            default: sel = SEL_ILLEGAL;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pc_return_stack_ras_lifo.sv
// rtl/pc_return_stack_ras_lifo.sv - return-address LIFO with wrapping sp and saturating count
module ras_lifo
    import pc_return_stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    // count alone decides full/empty; sp is just a wrapping index.
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign top     = empty ? '0 : mem[sp - PTR_ONE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[sp] <= push_data;
            sp      <= sp + PTR_ONE;
            count   <= count + CNT_ONE;
        end else if (do_pop) begin
            sp    <= sp - PTR_ONE;
            count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - fetch PC register, redirect/call/ret priority decode, sticky errors
module pc_return_stack
    import pc_return_stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] link_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              ctl_err
);

    ctl_sel_e          sel;
    logic [ADDR_W-1:0] pc_next;
    logic              push;
    logic              pop;
    logic              set_ovf;
    logic              set_unf;
    logic              set_ctl;

    ras_lifo u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (link_addr),
        .top       (ret_addr),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_comb begin
        sel     = decode_sel(redirect, call, ret);
        pc_next = pc + PC_STEP;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_ctl = 1'b0;
        // A stalled cycle must not touch the stack, so gate the strobes here.
        if (!stall) begin
            case (sel)
                SEL_ILLEGAL: set_ctl = 1'b1;
                SEL_CALL: begin
                    pc_next = target;
                    push    = !ras_full;
                    set_ovf = ras_full;
                end
                SEL_RET: begin
                    pc_next = ras_empty ? RESET_PC : ret_addr;
                    pop     = !ras_empty;
                    set_unf = ras_empty;
                end
                SEL_REDIRECT: pc_next = target;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            ctl_err <= 1'b0;
        end else if (!stall) begin
            pc      <= pc_next;
            ovf_err <= ovf_err | set_ovf;
            unf_err <= unf_err | set_unf;
            ctl_err <= ctl_err | set_ctl;
        end
    end

endmodule

// File: tb/tb_pc_return_stack.sv
// tb/tb_pc_return_stack.sv - directed vectors for pc_return_stack
module tb_pc_return_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       redirect;
    logic       call;
    logic       ret;
    logic [7:0] target;
    logic [7:0] link_addr;
    logic [7:0] pc;
    logic [7:0] ret_addr;
    logic       ras_empty;
    logic       ras_full;
    logic       ovf_err;
    logic       unf_err;
    logic       ctl_err;

    int n_vec = 0;
    int n_err = 0;

    pc_return_stack dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .redirect  (redirect),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .link_addr (link_addr),
        .pc        (pc),
        .ret_addr  (ret_addr),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
        .ctl_err   (ctl_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; applies controls across one posedge, returns at the next negedge.
    task automatic cyc(input logic r, input logic c, input logic t,
                       input logic [7:0] tg, input logic [7:0] lk, input logic st);
        redirect  = r;
        call      = c;
        ret       = t;
        target    = tg;
        link_addr = lk;
        stall     = st;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; call = 1'b0; ret = 1'b0;
        target = 8'h00; link_addr = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_pc", pc, 8'h00);
        chk("rst_empty", ras_empty, 1'b1);
        chk("rst_full", ras_full, 1'b0);
        chk("rst_errs", {ovf_err, unf_err, ctl_err}, 3'b000);
        chk("rst_ret_addr", ret_addr, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk($sformatf("seq_pc%0d", i), pc, i);
        end

        cyc(1'b1, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b0);
        chk("redir_pc", pc, 8'hFE);
        idle(); chk("wrap_ff", pc, 8'hFF);
        idle(); chk("wrap_00", pc, 8'h00);
        idle(); chk("wrap_01", pc, 8'h01);
        chk("wrap_noerr", {ovf_err, unf_err, ctl_err}, 3'b000);

        cyc(1'b0, 1'b1, 1'b0, 8'h40, 8'h11, 1'b0);
        chk("call1_pc", pc, 8'h40); chk("call1_ra", ret_addr, 8'h11);
        cyc(1'b0, 1'b1, 1'b0, 8'h60, 8'h41, 1'b0);
        chk("call2_pc", pc, 8'h60); chk("call2_ra", ret_addr, 8'h41);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        chk("ret1_pc", pc, 8'h41); chk("ret1_ra", ret_addr, 8'h11);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        chk("ret2_pc", pc, 8'h11); chk("ret2_ra", ret_addr, 8'h00);
        chk("ret2_empty", ras_empty, 1'b1);

        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h80 + 8'(i), 8'(i), 1'b0);
            if (i == 6) chk("fill7_notfull", ras_full, 1'b0);
            if (i == 7) begin
                chk("fill8_full", ras_full, 1'b1);
                chk("fill8_noovf", ovf_err, 1'b0);
            end
        end
        chk("ovf_err", ovf_err, 1'b1);
        chk("ovf_pc", pc, 8'h88);
        chk("ovf_ra", ret_addr, 8'h07);
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
            chk($sformatf("pop_pc%0d", i), pc, i);
        end
        chk("pop_empty", ras_empty, 1'b1);

        cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        chk("unf_pc", pc, 8'h00); chk("unf_err", unf_err, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0);
        chk("unf_redir_pc", pc, 8'h33); chk("unf_sticky", unf_err, 1'b1);

        cyc(1'b0, 1'b1, 1'b0, 8'h20, 8'h55, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h20, 8'h55, 1'b1);
        chk("stall_pc", pc, 8'h33); chk("stall_empty", ras_empty, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h20, 8'h55, 1'b0);
        chk("unstall_pc", pc, 8'h20); chk("unstall_ra", ret_addr, 8'h55);
        idle();
        chk("single_push_pc", pc, 8'h21);
        chk("single_push_ra", ret_addr, 8'h55);
        cyc(1'b0, 1'b1, 1'b1, 8'h70, 8'h99, 1'b0);
        chk("ctl_err", ctl_err, 1'b1); chk("ctl_pc", pc, 8'h22);
        chk("ctl_ra", ret_addr, 8'h55);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        chk("single_push_pop", pc, 8'h55); chk("single_push_empty", ras_empty, 1'b1);

        cyc(1'b0, 1'b1, 1'b0, 8'h90, 8'h12, 1'b0);
        redirect = 1'b0; call = 1'b0; ret = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 8'h00);
        chk("mid_rst_empty", ras_empty, 1'b1);
        chk("mid_rst_errs", {ovf_err, unf_err, ctl_err}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("post_rst_pc", pc, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
